// File: rtl/rob_dispatch.sv
// Dispatch sequencer between rename and the ROB: holds one renamed group of up to
// four instructions, inserts as many as the ROB has room for, and tracks ROB tags.
module rob_dispatch #(
  parameter int LEN    = 16,
  parameter int BWIDTH = 57,
  parameter int LBITS  = $clog2(LEN)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_grp_valid,
  input  logic [2:0]        i_grp_count,
  input  logic [BWIDTH-1:0] i_grp_bundle0,
  input  logic [BWIDTH-1:0] i_grp_bundle1,
  input  logic [BWIDTH-1:0] i_grp_bundle2,
  input  logic [BWIDTH-1:0] i_grp_bundle3,
  input  logic [5:0]        i_grp_old_p0,
  input  logic [5:0]        i_grp_old_p1,
  input  logic [5:0]        i_grp_old_p2,
  input  logic [5:0]        i_grp_old_p3,
  output logic              o_grp_ready,
  input  logic [LBITS-1:0]  i_rob_free,
  input  logic              i_flush,
  output logic [BWIDTH-1:0] o_ins_bundle0,
  output logic [BWIDTH-1:0] o_ins_bundle1,
  output logic [BWIDTH-1:0] o_ins_bundle2,
  output logic [BWIDTH-1:0] o_ins_bundle3,
  output logic [5:0]        o_ins_old_p0,
  output logic [5:0]        o_ins_old_p1,
  output logic [5:0]        o_ins_old_p2,
  output logic [5:0]        o_ins_old_p3,
  output logic [2:0]        o_ins_count,
  output logic [LBITS-1:0]  o_rob_tag0,
  output logic [LBITS-1:0]  o_rob_tag1,
  output logic [LBITS-1:0]  o_rob_tag2,
  output logic [LBITS-1:0]  o_rob_tag3,
  output logic [15:0]       o_stall_cycles
);

  typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

  state_t            state_r, state_s;
  logic [2:0]        buf_count_r, buf_count_s;
  logic [BWIDTH-1:0] bundle_r [4];
  logic [BWIDTH-1:0] bundle_s [4];
  logic [5:0]        old_p_r [4];
  logic [5:0]        old_p_s [4];
  logic [BWIDTH-1:0] grp_bundle_s [4];
  logic [5:0]        grp_old_p_s [4];
  logic [LBITS-1:0]  head_r;
  logic [15:0]       stall_r;
  logic [2:0]        lim_s, n_s;
  logic              buf_valid_s, full_drain_s, ready_s, accept_s;

  assign grp_bundle_s[0] = i_grp_bundle0;
  assign grp_bundle_s[1] = i_grp_bundle1;
  assign grp_bundle_s[2] = i_grp_bundle2;
  assign grp_bundle_s[3] = i_grp_bundle3;
  assign grp_old_p_s[0]  = i_grp_old_p0;
  assign grp_old_p_s[1]  = i_grp_old_p1;
  assign grp_old_p_s[2]  = i_grp_old_p2;
  assign grp_old_p_s[3]  = i_grp_old_p3;

  // Dispatch count and group handshake; free count compared at full width
  always_comb begin
    buf_valid_s = (state_r == HOLD);
    if ({{(32-LBITS){1'b0}}, i_rob_free} >= 32'd4) begin
      lim_s = 3'd4;
    end else begin
      lim_s = 3'(i_rob_free);
    end
    if (!buf_valid_s || i_flush) begin
      n_s = 3'd0;
    end else if (buf_count_r < lim_s) begin
      n_s = buf_count_r;
    end else begin
      n_s = lim_s;
    end
    full_drain_s = (n_s == buf_count_r);
    ready_s      = !i_flush && (!buf_valid_s || full_drain_s);
    accept_s     = i_grp_valid && ready_s;
  end

  // Next-state logic for buffer occupancy and slot contents
  always_comb begin
    logic [2:0] src;
    src         = 3'd0;
    state_s     = state_r;
    buf_count_s = buf_count_r;
    for (int k = 0; k < 4; k++) begin
      bundle_s[k] = bundle_r[k];
      old_p_s[k]  = old_p_r[k];
    end
    case (state_r)
      EMPTY: begin
        if (accept_s) begin
          state_s     = HOLD;
          buf_count_s = i_grp_count;
          for (int k = 0; k < 4; k++) begin
            bundle_s[k] = grp_bundle_s[k];
            old_p_s[k]  = grp_old_p_s[k];
          end
        end else begin
          state_s = EMPTY;
        end
      end
      HOLD: begin
        if (i_flush) begin
          state_s     = EMPTY;
          buf_count_s = 3'd0;
        end else if (accept_s) begin
          state_s     = HOLD;
          buf_count_s = i_grp_count;
          for (int k = 0; k < 4; k++) begin
            bundle_s[k] = grp_bundle_s[k];
            old_p_s[k]  = grp_old_p_s[k];
          end
        end else if (full_drain_s) begin
          state_s     = EMPTY;
          buf_count_s = 3'd0;
        end else begin
          // Partial drain: survivors move down so slot 0 stays the oldest
          buf_count_s = buf_count_r - n_s;
          for (int k = 0; k < 4; k++) begin
            src = 3'(k) + n_s;
            if (src < 3'd4) begin
              bundle_s[k] = bundle_r[src[1:0]];
              old_p_s[k]  = old_p_r[src[1:0]];
            end else begin
              bundle_s[k] = bundle_r[k];
              old_p_s[k]  = old_p_r[k];
            end
          end
        end
      end
      default: begin
        state_s     = EMPTY;
        buf_count_s = 3'd0;
      end
    endcase
  end

  // State, slot, head-mirror and stall-counter registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= EMPTY;
      buf_count_r <= 3'd0;
      head_r      <= '0;
      stall_r     <= 16'd0;
      for (int k = 0; k < 4; k++) begin
        bundle_r[k] <= '0;
        old_p_r[k]  <= 6'd0;
      end
    end else begin
      state_r     <= state_s;
      buf_count_r <= buf_count_s;
      head_r      <= head_r + LBITS'(n_s);
      for (int k = 0; k < 4; k++) begin
        bundle_r[k] <= bundle_s[k];
        old_p_r[k]  <= old_p_s[k];
      end
      if (buf_valid_s && !i_flush && (n_s < buf_count_r) && (stall_r != 16'hFFFF)) begin
        stall_r <= stall_r + 16'd1;
      end else begin
        stall_r <= stall_r;
      end
    end
  end

  assign o_grp_ready    = ready_s;
  assign o_ins_count    = n_s;
  assign o_ins_bundle0  = bundle_r[0];
  assign o_ins_bundle1  = bundle_r[1];
  assign o_ins_bundle2  = bundle_r[2];
  assign o_ins_bundle3  = bundle_r[3];
  assign o_ins_old_p0   = old_p_r[0];
  assign o_ins_old_p1   = old_p_r[1];
  assign o_ins_old_p2   = old_p_r[2];
  assign o_ins_old_p3   = old_p_r[3];
  assign o_rob_tag0     = head_r;
  assign o_rob_tag1     = head_r + LBITS'(1);
  assign o_rob_tag2     = head_r + LBITS'(2);
  assign o_rob_tag3     = head_r + LBITS'(3);
  assign o_stall_cycles = stall_r;

endmodule

// File: tb/tb_rob_dispatch.sv
// Self-checking bench for rob_dispatch: directed vector table, hand-written
// reset/saturation sequences, and random traffic against a queue-based model.
module tb_rob_dispatch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        gv;
  logic [2:0]  grp_count;
  logic [56:0] gb [4];
  logic [5:0]  gp [4];
  logic        grp_ready;
  logic [3:0]  rob_free;
  logic        flush;
  logic [56:0] ib [4];
  logic [5:0]  ip [4];
  logic [2:0]  ins_count;
  logic [3:0]  tag [4];
  logic [15:0] stall;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rob_dispatch dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_grp_valid(gv), .i_grp_count(grp_count),
    .i_grp_bundle0(gb[0]), .i_grp_bundle1(gb[1]), .i_grp_bundle2(gb[2]), .i_grp_bundle3(gb[3]),
    .i_grp_old_p0(gp[0]), .i_grp_old_p1(gp[1]), .i_grp_old_p2(gp[2]), .i_grp_old_p3(gp[3]),
    .o_grp_ready(grp_ready), .i_rob_free(rob_free), .i_flush(flush),
    .o_ins_bundle0(ib[0]), .o_ins_bundle1(ib[1]), .o_ins_bundle2(ib[2]), .o_ins_bundle3(ib[3]),
    .o_ins_old_p0(ip[0]), .o_ins_old_p1(ip[1]), .o_ins_old_p2(ip[2]), .o_ins_old_p3(ip[3]),
    .o_ins_count(ins_count),
    .o_rob_tag0(tag[0]), .o_rob_tag1(tag[1]), .o_rob_tag2(tag[2]), .o_rob_tag3(tag[3]),
    .o_stall_cycles(stall)
  );

  typedef struct {
    bit gv; int g; int cnt; int free; bit fl;
    int ecnt; bit erdy; int etag; int eg; int ek0; int estall;
  } vec_t;

  typedef struct {
    logic [56:0] b;
    logic [5:0]  p;
  } ent_t;

  vec_t tbl[$];
  ent_t q[$];

  function automatic logic [56:0] mk_b(int g, int k);
    return 57'(g * 256 + k);
  endfunction

  function automatic logic [5:0] mk_p(int g, int k);
    return 6'(g * 4 + k);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; gv = 1'b0; flush = 1'b0; rob_free = 4'd0; grp_count = 3'd1;
    for (int k = 0; k < 4; k++) begin gb[k] = '0; gp[k] = '0; end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drive_grp(input bit v, input int g, input int cnt, input int free, input bit fl);
    gv = v; grp_count = 3'(cnt); rob_free = 4'(free); flush = fl;
    for (int k = 0; k < 4; k++) begin gb[k] = mk_b(g, k); gp[k] = mk_p(g, k); end
  endtask

  initial begin
    int sz, mn, mhead, mstall, free_i, cnt_i;
    bit mrdy;

    rst_n = 1'b0; gv = 1'b0; flush = 1'b0; rob_free = 4'd0; grp_count = 3'd1;
    for (int k = 0; k < 4; k++) begin gb[k] = '0; gp[k] = '0; end
    @(negedge clk);
    chk("rst_count", 64'(ins_count), 64'd0);
    chk("rst_ready", 64'(grp_ready), 64'd1);
    chk("rst_stall", 64'(stall), 64'd0);
    for (int k = 0; k < 4; k++) chk("rst_tag", 64'(tag[k]), 64'(k));
    do_reset();

    // gv g cnt free fl | ecnt erdy etag eg ek0 estall
    tbl.push_back('{1, 1, 3, 15, 0, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 15, 0, 3, 1, 0, 1, 0, 0});
    tbl.push_back('{1, 2, 4, 15, 0, 0, 1, 3, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 1,  0, 1, 0, 3, 2, 0, 0});
    tbl.push_back('{0, 0, 1, 2,  0, 2, 0, 4, 2, 1, 1});
    tbl.push_back('{1, 3, 4, 15, 0, 1, 1, 6, 2, 3, 2});
    tbl.push_back('{1, 4, 4, 15, 0, 4, 1, 7, 3, 0, 2});
    tbl.push_back('{1, 5, 4, 4,  0, 4, 1, 11, 4, 0, 2});
    tbl.push_back('{0, 0, 1, 0,  0, 0, 0, 15, 0, 0, 2});
    tbl.push_back('{1, 6, 2, 0,  0, 0, 0, 15, 0, 0, 3});
    tbl.push_back('{1, 6, 2, 15, 1, 0, 0, 15, 0, 0, 4});
    tbl.push_back('{1, 7, 4, 15, 0, 0, 1, 15, 0, 0, 4});
    tbl.push_back('{0, 0, 1, 15, 0, 4, 1, 15, 7, 0, 4});
    tbl.push_back('{1, 8, 2, 3,  1, 0, 0, 3, 0, 0, 4});
    tbl.push_back('{0, 0, 1, 15, 0, 0, 1, 3, 0, 0, 4});

    for (int i = 0; i < tbl.size(); i++) begin
      drive_grp(tbl[i].gv, tbl[i].g, tbl[i].cnt, tbl[i].free, tbl[i].fl);
      @(negedge clk);
      chk($sformatf("tbl%0d_count", i), 64'(ins_count), 64'(tbl[i].ecnt));
      chk($sformatf("tbl%0d_ready", i), 64'(grp_ready), 64'(tbl[i].erdy));
      chk($sformatf("tbl%0d_stall", i), 64'(stall), 64'(tbl[i].estall));
      for (int k = 0; k < 4; k++)
        chk($sformatf("tbl%0d_tag%0d", i, k), 64'(tag[k]), 64'((tbl[i].etag + k) % 16));
      for (int k = 0; k < tbl[i].ecnt; k++) begin
        chk($sformatf("tbl%0d_bundle%0d", i, k), 64'(ib[k]), 64'(mk_b(tbl[i].eg, tbl[i].ek0 + k)));
        chk($sformatf("tbl%0d_oldp%0d", i, k), 64'(ip[k]), 64'(mk_p(tbl[i].eg, tbl[i].ek0 + k)));
      end
      @(posedge clk);
      #1;
    end

    // Asynchronous reset while two instructions are still held
    do_reset();
    drive_grp(1, 9, 4, 15, 0);
    @(posedge clk); #1;
    drive_grp(0, 0, 1, 2, 0);
    @(posedge clk); #1;
    rob_free = 4'd15;
    #3;
    chk("pre_rst_count", 64'(ins_count), 64'd2);
    chk("pre_rst_tag0", 64'(tag[0]), 64'd2);
    chk("pre_rst_stall", 64'(stall), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", 64'(ins_count), 64'd0);
    chk("async_rst_tag0", 64'(tag[0]), 64'd0);
    chk("async_rst_tag3", 64'(tag[3]), 64'd3);
    chk("async_rst_stall", 64'(stall), 64'd0);
    chk("async_rst_ready", 64'(grp_ready), 64'd1);
    @(posedge clk); #1 rst_n = 1'b1;

    // Stall counter saturation
    do_reset();
    drive_grp(1, 10, 1, 0, 0);
    @(posedge clk); #1;
    gv = 1'b0;
    repeat (65534) @(posedge clk);
    #1;
    chk("stall_fffe", 64'(stall), 64'hFFFE);
    repeat (6) @(posedge clk);
    #1;
    chk("stall_sat", 64'(stall), 64'hFFFF);
    chk("stall_sat_count", 64'(ins_count), 64'd0);

    // Random traffic against a queue model
    do_reset();
    q.delete();
    mhead = 0;
    mstall = 0;
    for (int c = 0; c < 2000; c++) begin
      gv = 1'($urandom_range(0, 1));
      cnt_i = $urandom_range(1, 4);
      grp_count = 3'(cnt_i);
      for (int k = 0; k < 4; k++) begin
        gb[k] = 57'({$urandom(), $urandom()});
        gp[k] = 6'($urandom());
      end
      free_i = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 15);
      rob_free = 4'(free_i);
      flush = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      sz = q.size();
      if (flush || sz == 0) mn = 0;
      else begin
        mn = sz;
        if (free_i < mn) mn = free_i;
        if (4 < mn) mn = 4;
      end
      mrdy = !flush && (sz == 0 || mn == sz);
      chk("rnd_count", 64'(ins_count), 64'(mn));
      chk("rnd_ready", 64'(grp_ready), 64'(mrdy));
      chk("rnd_stall", 64'(stall), 64'(mstall));
      for (int k = 0; k < 4; k++) chk("rnd_tag", 64'(tag[k]), 64'((mhead + k) % 16));
      for (int k = 0; k < mn; k++) begin
        chk("rnd_bundle", 64'(ib[k]), 64'(q[k].b));
        chk("rnd_oldp", 64'(ip[k]), 64'(q[k].p));
      end
      @(posedge clk);
      if (flush) q.delete();
      else begin
        if (sz > 0 && mn < sz && mstall < 65535) mstall++;
        for (int k = 0; k < mn; k++) void'(q.pop_front());
      end
      if (gv && mrdy)
        for (int k = 0; k < cnt_i; k++) q.push_back('{gb[k], gp[k]});
      mhead = (mhead + mn) % 16;
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rob_dispatch.md
# rob_dispatch

Dispatch sequencer between rename and the reorder buffer. Holds one renamed group of up to four instructions, hands as many as the ROB has room for to its insert port each cycle (in program order, partial groups allowed), and keeps the remainder until later cycles. Mirrors the ROB head pointer so every inserted instruction gets its ROB tag for the execution units. Counts dispatch-stall cycles for performance monitoring.

## Interface
- LEN, 16, ROB entries; must match the ROB.
- BWIDTH, 57, instruction bundle width.
- LBITS, $clog2(LEN), ROB tag width.

Ports:
- i_clk  in  1  clock; single clock domain.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_grp_valid  in  1  rename offers a group.
- i_grp_count  in  3  instructions in the group, 1..4 when valid.
- i_grp_bundle0..3  in  BWIDTH each  bundles, slot 0 oldest.
- i_grp_old_p0..3  in  6 each  old physical registers.
- o_grp_ready  out  1  group accepted when valid && ready at the clock edge.
- i_rob_free  in  LBITS  ROB free-entry count.
- i_flush  in  1  discard the held group.
- o_ins_bundle0..3  out  BWIDTH each  to ROB insert port.
- o_ins_old_p0..3  out  6 each  to ROB insert port.
- o_ins_count  out  3  instructions inserted this cycle, 0..4.
- o_rob_tag0..3  out  LBITS each  ROB index of each inserted slot.
- o_stall_cycles  out  16  saturating stall counter.

## Operation
- State: buf_valid, buf_count (3 b), four bundle/old_p slots, head (LBITS), stall counter.
- Dispatch count n = 0 if !buf_valid or i_flush, else min(buf_count, i_rob_free, 4). The comparison is done at full width: i_rob_free >= 4 means no limit.
- o_ins_count = n. o_ins_bundle/old_p slot k = buffer slot k. Output slots k >= n are don't-care, but are driven from the buffer and never X.
- o_rob_tagk = head + k, mod LEN (natural LBITS wrap).
- head <= head + n every cycle. This keeps it in step with the ROB head. Flush does not move head.
- Drain: if n == buf_count, the buffer empties. Otherwise, remaining entries shift down by n (slot k <= slot k+n), buf_count <= buf_count - n, and buf_valid stays 1.
- o_grp_ready = !i_flush && (!buf_valid || n == buf_count). It is combinational, so a group can be accepted in the same cycle the previous one fully drains.
- Accept (valid && ready): load all four slots from i_grp_*, set buf_count <= i_grp_count and buf_valid <= 1.
- i_flush: buf_valid <= 0, n = 0, no accept that cycle.
- Stall counter increments when buf_valid && !i_flush && n < buf_count. It saturates at 16'hFFFF.
- States: EMPTY (buf_valid=0) and HOLD (buf_valid=1).
  - EMPTY -> HOLD on accept.
  - HOLD -> EMPTY on full drain without accept, or on flush.
  - HOLD -> HOLD on partial drain, or on full drain with accept.
- Invariant: 1 <= buf_count <= 4 whenever buf_valid.

## Timing
- Reset values:
  - buf_valid=0, buf_count=0, head=0, slots=0, o_stall_cycles=0.
  - Hence o_ins_count=0, o_rob_tag0..3 = 0,1,2,3, and o_grp_ready=1 (when i_flush=0).
- Latency: a group accepted at edge T appears on o_ins_* during cycle T+1. It is inserted by the ROB at edge T+1 if room allows.
- o_ins_*, o_rob_tag*, o_grp_ready are combinational from state plus i_rob_free/i_flush. No combinational path from i_grp_* to o_ins_*.
- i_rob_free == 0 while holding: n=0, ready=0, head unchanged, stall counter increments.
- head wrap: with head = LEN-2 and n=4, the tags are LEN-2, LEN-1, 0, 1, and head becomes 2.
- Reset asserted mid-group: the buffer is dropped immediately and everything returns to reset values. The ROB is reset on the same signal, so head=0 remains consistent.

## Test plan
- Reset, then group count=3 valid with i_rob_free=15 -> next cycle o_ins_count=3 and tags 0,1,2. The cycle after, head=3 and o_grp_ready=1.
- Group of 4 with i_rob_free=1, then i_rob_free=2, then 15 -> o_ins_count 1, 2, 1 on successive cycles. Slot 0 carries bundles 0, 1, 3 in turn. ready=0 until the last cycle. o_stall_cycles=2.
- Back-to-back groups of 4 with i_rob_free=15 -> o_ins_count=4 every cycle with no bubble, and tags advance by 4 and wrap 12,13,14,15 -> 0,1,2,3.
- Hold a group with i_rob_free=0 for 3 cycles, then pulse i_flush -> o_ins_count=0 throughout, o_stall_cycles=3, and after the flush buf empty and head unchanged.
- Assert i_rst_n=0 asynchronously while holding 2 instructions -> o_ins_count=0, head=0 and o_stall_cycles=0 immediately, without waiting for a clock edge.
- Stall counter: hold i_rob_free=0 for 65540 cycles -> o_stall_cycles=16'hFFFF with no wrap.
